// File: rtl/env_scan.sv
// env_scan: snapshots two 16x16 Game of Life environments on start and streams
// every cell of the new generation in row-major order over valid/ready,
// tallying live cells, births and deaths along the way.
// Optional feature: define ENV_SCAN_COUNT_EN to build the live/birth/death
// counters and the prev_env snapshot; otherwise the counts read as 0.
module env_scan #(
   parameter  int ROWS  = 16,
   parameter  int COLS  = 16,
   parameter  int CNT_W = 9,
   localparam int RW    = $clog2(ROWS),
   localparam int CW    = $clog2(COLS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ROWS*COLS-1:0] prev_env,
   input  logic [ROWS*COLS-1:0] next_env,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [RW-1:0]        out_row,
   output logic [CW-1:0]        out_col,
   output logic                 out_alive,
   output logic                 out_last,
   output logic                 done,
   output logic [CNT_W-1:0]     live_cnt,
   output logic [CNT_W-1:0]     birth_cnt,
   output logic [CNT_W-1:0]     death_cnt
);

   localparam int IW = $clog2(ROWS*COLS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [RW-1:0]          row_q, row_d;
   logic [CW-1:0]          col_q, col_d;
   logic [ROWS*COLS-1:0]   next_q;
   logic                   snap_load;
   logic                   accept;
   logic [IW-1:0]          idx;

   // Flat bit index of the current cell in the environment vectors.
   assign idx = IW'(row_q) * IW'(COLS) + IW'(col_q);

   // Beat fields come straight from registers, so out_valid never depends on out_ready.
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_SCAN);
   assign out_row   = row_q;
   assign out_col   = col_q;
   assign out_alive = out_valid && next_q[idx];
   assign out_last  = out_valid && (row_q == RW'(ROWS-1)) && (col_q == CW'(COLS-1));
   assign done      = (state_q == S_DONE);
   assign accept    = out_valid && out_ready;

   // Next-state logic: scan sequencing and row-major index advance.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      snap_load = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_SCAN;
               row_d     = '0;
               col_d     = '0;
               snap_load = 1'b1;
            end
         end
         S_SCAN: begin
            if (accept) begin
               if (out_last) begin
                  state_d = S_DONE;
                  row_d   = '0;
                  col_d   = '0;
               end else if (col_q == CW'(COLS-1)) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, index and next-generation snapshot registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         // NOTE: the snapshot is reset so out_alive reads 0 after reset, not stale board data.
         next_q  <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         if (snap_load) next_q <= next_env;
      end
   end

`ifdef ENV_SCAN_COUNT_EN
   logic [ROWS*COLS-1:0] prev_q;
   logic [CNT_W-1:0]     live_q, live_d;
   logic [CNT_W-1:0]     birth_q, birth_d;
   logic [CNT_W-1:0]     death_q, death_d;
   logic                 cur_prev, cur_next;

   assign cur_prev = prev_q[idx];
   assign cur_next = next_q[idx];

   // Tally update: clear on an accepted start, bump per accepted cell.
   always_comb begin
      live_d  = live_q;
      birth_d = birth_q;
      death_d = death_q;
      if (snap_load) begin
         live_d  = '0;
         birth_d = '0;
         death_d = '0;
      end else if (accept) begin
         live_d  = live_q  + CNT_W'(cur_next);
         birth_d = birth_q + CNT_W'(!cur_prev && cur_next);
         death_d = death_q + CNT_W'(cur_prev && !cur_next);
      end
   end

   // Previous-generation snapshot and tally registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q  <= '0;
         live_q  <= '0;
         birth_q <= '0;
         death_q <= '0;
      end else begin
         if (snap_load) prev_q <= prev_env;
         live_q  <= live_d;
         birth_q <= birth_d;
         death_q <= death_d;
      end
   end

   assign live_cnt  = live_q;
   assign birth_cnt = birth_q;
   assign death_cnt = death_q;
`else
   logic unused_prev_env;

   assign unused_prev_env = ^prev_env;
   assign live_cnt        = '0;
   assign birth_cnt       = '0;
   assign death_cnt       = '0;
`endif

endmodule

// File: tb/tb_env_scan.sv
// Self-checking bench for env_scan: a scoreboard queue holds the expected beat
// sequence for each scan; the monitor pops and compares on every accepted beat
// and checks the tallies when done pulses.
module tb_env_scan;
   localparam int ROWS  = 16;
   localparam int COLS  = 16;
   localparam int CNT_W = 9;
   localparam int N     = ROWS*COLS;
`ifdef ENV_SCAN_COUNT_EN
   localparam bit COUNT_EN = 1'b1;
`else
   localparam bit COUNT_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             out_ready = 1'b0;
   logic [N-1:0]     prev_env = '0;
   logic [N-1:0]     next_env = '0;
   logic             busy, out_valid, out_alive, out_last, done;
   logic [3:0]       out_row, out_col;
   logic [CNT_W-1:0] live_cnt, birth_cnt, death_cnt;

   env_scan #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .prev_env(prev_env), .next_env(next_env),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_col(out_col), .out_alive(out_alive),
      .out_last(out_last), .done(done),
      .live_cnt(live_cnt), .birth_cnt(birth_cnt), .death_cnt(death_cnt)
   );

   always #5 clk = ~clk;

   int               n_tests = 0;
   int               n_fail  = 0;
   logic [9:0]       exp_q[$];
   logic [CNT_W-1:0] exp_live, exp_birth, exp_death;
   bit               rand_ready;
   int               beats, done_seen, cyc, done_cyc;
   bit               stalled;
   logic [9:0]       held;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] all_out();
      return {busy, out_valid, out_row, out_col, out_alive, out_last, done,
              live_cnt, birth_cnt, death_cnt};
   endfunction

   function automatic logic [N-1:0] rand_env();
      logic [N-1:0] v;
      for (int i = 0; i < N/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Observe DUT at the falling edge, after choosing the ready the next rising edge sees.
   task automatic step();
      logic [9:0] beat;
      @(negedge clk);
      cyc++;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      beat = {out_row, out_col, out_alive, out_last};
      if (stalled) check("stall_hold", {out_valid, beat}, {1'b1, held});
      stalled = out_valid && !out_ready;
      held    = beat;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) check("beat_extra", 1, 0);
         else                   check("beat", beat, exp_q.pop_front());
         beats++;
      end
      if (done) begin
         done_seen++;
         done_cyc = cyc;
         check("live_cnt",  live_cnt,  exp_live);
         check("birth_cnt", birth_cnt, exp_birth);
         check("death_cnt", death_cnt, exp_death);
         check("all_beats", exp_q.size(), 0);
      end
   endtask

   task automatic run_scan(input logic [N-1:0] p, input logic [N-1:0] n, input bit rr,
                           input int abort_at, input int start_at);
      int lv, bi, de;
      lv = 0; bi = 0; de = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         exp_q.push_back({4'(i / COLS), 4'(i % COLS), n[i], 1'(i == N-1)});
         lv += int'(n[i]);
         bi += int'(!p[i] && n[i]);
         de += int'(p[i] && !n[i]);
      end
      exp_live  = COUNT_EN ? CNT_W'(lv) : '0;
      exp_birth = COUNT_EN ? CNT_W'(bi) : '0;
      exp_death = COUNT_EN ? CNT_W'(de) : '0;
      rand_ready = rr;
      beats = 0; done_seen = 0; cyc = 0; done_cyc = 0; stalled = 0;

      @(negedge clk);
      prev_env = p; next_env = n; start = 1'b1;
      step();
      start = 1'b0;
      prev_env = ~p; next_env = rand_env();
      check("busy_after_start", {busy, out_valid}, 2'b11);
      while (done_seen == 0 && cyc < 3000) begin
         if (abort_at > 0 && beats == abort_at) begin
            rst = 1'b1;
            #1;
            check("reset_mid_scan", all_out(), 0);
            rst = 1'b0;
            @(negedge clk);
            check("after_reset", all_out(), 0);
            exp_q.delete();
            stalled = 0;
            return;
         end
         step();
         start = (start_at > 0) && (beats == start_at || done == 1'b1);
      end
      check("done_seen", done_seen, 1);
      if (!rr && start_at == 0) check("done_latency", done_cyc, 257);
      step();
      start = 1'b0;
      check("idle_after_done", {busy, out_valid, done}, 3'b000);
      check("single_done", done_seen, 1);
   endtask

   initial begin
      logic [N-1:0] bp, bn;
      rand_ready = 0;
      stalled = 0;
      repeat (2) @(negedge clk);
      check("reset_outputs", all_out(), 0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_outputs", all_out(), 0);
      end

      run_scan('0, '0, 1'b0, 0, 0);

      bp = '0; bn = '0;
      bp[7*COLS+6] = 1'b1; bp[7*COLS+7] = 1'b1; bp[7*COLS+8] = 1'b1;
      bn[6*COLS+7] = 1'b1; bn[7*COLS+7] = 1'b1; bn[8*COLS+7] = 1'b1;
      run_scan(bp, bn, 1'b0, 0, 0);
      if (COUNT_EN) begin
         check("blinker_live",  exp_live,  3);
         check("blinker_birth", exp_birth, 2);
         check("blinker_death", exp_death, 2);
      end

      run_scan('0, '1, 1'b0, 0, 0);
      run_scan(rand_env(), rand_env(), 1'b1, 0, 0);
      run_scan(rand_env(), rand_env(), 1'b1, 0, 100);
      run_scan(rand_env(), rand_env(), 1'b0, 37, 0);
      run_scan(rand_env(), rand_env(), 1'b1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
